product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Consumes signed 64-bit products from the multiplier block and holds them in a HI/LO accumulator pair.
- Supports load, multiply-accumulate and multiply-subtract, plus direct 32-bit writes to HI or LO from the register-file side.
- Has a one-entry input buffer with valid/ready handshake, so the multiplier can hand off a result even when the accumulator is busy with a direct write.

Parameters:
- SATURATE, 0: when 1, a signed-overflowing ADD/SUB clamps to the 64-bit signed max/min; when 0, the result wraps.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- prod_valid  in  1  product available.
- prod_ready  out  1  block can accept a product this cycle.
- prod_data  in  64  signed product {hi, lo}.
- prod_op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 reserved.
- wr_en  in  1  direct register write.
- wr_sel  in  1  0 writes LO, 1 writes HI.
- wr_data  in  32  direct write data.
- clr_ovf  in  1  clears the sticky overflow flag.
- hi  out  32  accumulator bits [63:32].
- lo  out  32  accumulator bits [31:0].
- acc_done  out  1  one-cycle pulse: accumulator updated from a product.
- ovf  out  1  sticky signed-overflow flag.

Behaviour:
- Reset (rst=1 at posedge): hi=0, lo=0, buffer empty, acc_done=0, ovf=0.
  - Reset mid-operation discards any buffered product; no update follows.
- Handshake:
  - A product transfers on a posedge where prod_valid=1 and prod_ready=1. It is captured into the buffer (data + op); buf_valid is set.
  - prod_ready = ~buf_valid | ~wr_en (combinational). The buffer drains in any cycle without wr_en. Drain and a new accept may occur on the same edge.
  - prod_data and prod_op are sampled only on transfer. They may change freely otherwise.
- Accumulate stage, on a posedge with buf_valid=1 and wr_en=0:
  - LOAD: acc <= buf_data.
  - ADD: acc <= acc + buf_data.
  - SUB: acc <= acc - buf_data.
  - reserved op: acc unchanged.
  - In all four cases buf_valid clears (unless refilled the same edge) and acc_done is 1 for the next cycle.
- Latency: transfer at edge E, accumulator update at edge E+1 (when uncontended), so hi/lo and acc_done are visible in the cycle after E+1. Back-to-back products sustain one per cycle.
- Direct write (wr_en=1) has priority over the accumulate stage:
  - Writes wr_data into LO (wr_sel=0) or HI (wr_sel=1); the other half is unchanged.
  - A buffered product stalls and is held intact. It accumulates against the post-write value once wr_en drops.
  - acc_done=0 on direct writes.
- Arithmetic: full 64-bit two's complement.
  - ADD overflow when acc[63]==buf[63] and result[63]!=acc[63].
  - SUB overflow when acc[63]!=buf[63] and result[63]!=acc[63].
  - LOAD and reserved ops never overflow.
- On overflow, ovf is set at the same edge as the update.
  - SATURATE=1: acc <= 0x7FFFFFFF_FFFFFFFF if acc is non-negative, else 0x80000000_00000000.
  - SATURATE=0: the wrapped result is stored.
- ovf stays set until clr_ovf or rst.
  - clr_ovf and a new overflow on the same edge: ovf ends up 1 (set wins).
- acc_done is registered and is never high for two cycles from one product.

Test Plan:
- Reset, then LOAD 0x00000001_00000002 -> after two edges hi=0x00000001, lo=0x00000002, acc_done pulses once, ovf=0.
- LOAD 0x00000000_FFFFFFFF, then ADD 0x00000000_00000001 back-to-back with prod_valid held -> prod_ready stays 1 and the final hi=1, lo=0 (carry from LO into HI).
- Buffered ADD 5 while wr_en=1, wr_sel=1, wr_data=0x10 held 3 cycles -> prod_ready=0 during the stall, hi/lo unchanged except HI=0x10. After wr_en drops: acc = 0x00000010_00000005 (if LO was 0), acc_done pulses once.
- acc=0x7FFFFFFF_FFFFFFFF, ADD 1 -> SATURATE=0 gives 0x80000000_00000000 with ovf=1; SATURATE=1 gives 0x7FFFFFFF_FFFFFFFF with ovf=1. Then clr_ovf -> ovf=0.
- acc=0x80000000_00000000, SUB 1 -> ovf=1. With SATURATE=1, acc stays 0x80000000_00000000.
- Accept a product, then assert rst on the next edge -> hi=lo=0, acc_done never pulses, prod_ready=1 after reset. Reserved op 11 with acc=0x1234 -> acc unchanged, acc_done pulses.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: HI/LO 64-bit accumulator fed by signed products through a
// one-entry valid/ready buffer, with direct 32-bit HI/LO writes and sticky overflow.
module product_accumulator #(
  parameter bit SATURATE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prod_valid,
  output logic        prod_ready,
  input  logic [63:0] prod_data,
  input  logic [1:0]  prod_op,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [31:0] wr_data,
  input  logic        clr_ovf,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        acc_done,
  output logic        ovf
);

  localparam int unsigned ACC_W  = 64;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    op_e              op;
  } prod_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc_q, acc_d;
  prod_t            buf_q, buf_d;
  logic             buf_valid_q, buf_valid_d;
  logic             acc_done_q, acc_done_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sum_c, diff_c, sat_c;
  logic             add_ovf_c, sub_ovf_c, ovf_set_c;

  // Buffer can take a product unless it is full and stalled behind a direct write.
  assign prod_ready = ~buf_valid_q | ~wr_en;

  // Next-state: direct write wins, otherwise drain the buffer into the accumulator.
  always_comb begin
    acc_d       = acc_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    acc_done_d  = 1'b0;
    ovf_set_c   = 1'b0;

    sum_c     = acc_q + buf_q.data;
    diff_c    = acc_q - buf_q.data;
    add_ovf_c = (acc_q[ACC_W-1] == buf_q.data[ACC_W-1]) && (sum_c[ACC_W-1]  != acc_q[ACC_W-1]);
    sub_ovf_c = (acc_q[ACC_W-1] != buf_q.data[ACC_W-1]) && (diff_c[ACC_W-1] != acc_q[ACC_W-1]);
    sat_c     = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;

    if (wr_en) begin
      if (wr_sel) acc_d[ACC_W-1:HALF_W] = wr_data;
      else        acc_d[HALF_W-1:0]     = wr_data;
    end else if (buf_valid_q) begin
      buf_valid_d = 1'b0;
      acc_done_d  = 1'b1;
      case (buf_q.op)
        OP_LOAD: acc_d = buf_q.data;
        OP_ADD: begin
          ovf_set_c = add_ovf_c;
          acc_d     = (add_ovf_c && SATURATE) ? sat_c : sum_c;
        end
        OP_SUB: begin
          ovf_set_c = sub_ovf_c;
          acc_d     = (sub_ovf_c && SATURATE) ? sat_c : diff_c;
        end
        default: acc_d = acc_q;
      endcase
    end

    if (prod_valid && prod_ready) begin
      buf_d.data  = prod_data;
      buf_d.op    = op_e'(prod_op);
      buf_valid_d = 1'b1;
    end

    // A new overflow outranks a same-cycle clear.
    ovf_d = (ovf_q & ~clr_ovf) | ovf_set_c;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      acc_done_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      acc_done_q  <= acc_done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign hi       = acc_q[ACC_W-1:HALF_W];
  assign lo       = acc_q[HALF_W-1:0];
  assign acc_done = acc_done_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: wrapping and saturating instances share stimulus.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        prod_valid;
  logic [63:0] prod_data;
  logic [1:0]  prod_op;
  logic        wr_en;
  logic        wr_sel;
  logic [31:0] wr_data;
  logic        clr_ovf;

  logic        ready0, done0, ovf0, ready1, done1, ovf1;
  logic [31:0] hi0, lo0, hi1, lo1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_acc [2];
  logic        m_ovf [2];
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];

  always #5 clk = ~clk;

  product_accumulator #(.SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(ready0),
    .prod_data(prod_data), .prod_op(prod_op), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .clr_ovf(clr_ovf), .hi(hi0), .lo(lo0),
    .acc_done(done0), .ovf(ovf0)
  );

  product_accumulator #(.SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(ready1),
    .prod_data(prod_data), .prod_op(prod_op), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .clr_ovf(clr_ovf), .hi(hi1), .lo(lo1),
    .acc_done(done1), .ovf(ovf1)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic via 65-bit sign extension; k=1 is the saturating instance.
  function automatic void model_apply(input int k, input logic [63:0] d,
                                      input logic [1:0] op, input logic clr);
    logic [64:0] ext;
    logic [63:0] res;
    logic        ov;
    ov  = 1'b0;
    res = m_acc[k];
    case (op)
      2'b00: res = d;
      2'b01: begin
        ext = {m_acc[k][63], m_acc[k]} + {d[63], d};
        res = ext[63:0];
        ov  = ext[64] ^ ext[63];
      end
      2'b10: begin
        ext = {m_acc[k][63], m_acc[k]} - {d[63], d};
        res = ext[63:0];
        ov  = ext[64] ^ ext[63];
      end
      default: res = m_acc[k];
    endcase
    if (ov && k == 1) res = m_acc[k][63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    m_acc[k] = res;
    m_ovf[k] = (m_ovf[k] & ~clr) | ov;
  endfunction

  task automatic push_model(input logic [63:0] d, input logic [1:0] op, input logic clr);
    model_apply(0, d, op, clr);
    model_apply(1, d, op, clr);
    exp_q0.push_back(m_acc[0]);
    exp_q1.push_back(m_acc[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    prod_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Presents a product and returns just after the transfer edge with prod_valid still high.
  task automatic send(input logic [63:0] d, input logic [1:0] op, input logic clr);
    int n;
    prod_valid = 1'b1;
    prod_data  = d;
    prod_op    = op;
    #1;
    n = 0;
    while (!ready0 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check_eq("send_timeout", 64'd0, 64'd1);
    push_model(d, op, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    prod_valid = 1'b0;
    wr_en      = 1'b0;
    clr_ovf    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = '0;
      m_ovf[k] = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_acc_w"}, {hi0, lo0}, m_acc[0]);
    check_eq({tag, "_acc_s"}, {hi1, lo1}, m_acc[1]);
    check_eq({tag, "_ovf_w"}, 64'(ovf0), 64'(m_ovf[0]));
    check_eq({tag, "_ovf_s"}, 64'(ovf1), 64'(m_ovf[1]));
  endtask

  // Scoreboard: every acc_done pulse must match the oldest pending expectation.
  always @(posedge clk) begin
    logic [63:0] e;
    #1;
    if (done0) begin
      if (exp_q0.size() == 0) check_eq("unexp_done_w", 64'd1, 64'd0);
      else begin
        e = exp_q0.pop_front();
        check_eq("sb_acc_w", {hi0, lo0}, e);
      end
    end
    if (done1) begin
      if (exp_q1.size() == 0) check_eq("unexp_done_s", 64'd1, 64'd0);
      else begin
        e = exp_q1.pop_front();
        check_eq("sb_acc_s", {hi1, lo1}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; prod_valid = 1'b0; prod_data = '0; prod_op = '0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0; clr_ovf = 1'b0;
    do_reset();
    check_eq("rst_acc", {hi0, lo0}, 64'd0);
    check_eq("rst_done", 64'(done0), 64'd0);
    check_eq("rst_ovf", 64'(ovf0), 64'd0);
    check_eq("rst_ready", 64'(ready0), 64'd1);

    // Simple load
    send(64'h0000_0001_0000_0002, 2'b00, 1'b0);
    idle(3);
    check_eq("load_acc", {hi0, lo0}, 64'h0000_0001_0000_0002);
    check_state("load");

    // Back-to-back load then add with carry from LO into HI
    send(64'h0000_0000_FFFF_FFFF, 2'b00, 1'b0);
    check_eq("b2b_ready", 64'(ready0), 64'd1);
    send(64'h0000_0000_0000_0001, 2'b01, 1'b0);
    idle(3);
    check_eq("carry_acc", {hi0, lo0}, 64'h0000_0001_0000_0000);

    // Product stalls behind a three-cycle HI write
    send(64'd0, 2'b00, 1'b0);
    idle(3);
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 32'h10;
    m_acc[0][63:32] = 32'h10;
    m_acc[1][63:32] = 32'h10;
    send(64'd5, 2'b01, 1'b0);
    prod_valid = 1'b0;
    #1;
    check_eq("stall_ready0", 64'(ready0), 64'd0);
    tick();
    check_eq("stall_ready1", 64'(ready0), 64'd0);
    check_eq("stall_acc", {hi0, lo0}, 64'h0000_0010_0000_0000);
    check_eq("stall_done", 64'(done0), 64'd0);
    tick();
    wr_en = 1'b0;
    idle(3);
    check_eq("stall_final", {hi0, lo0}, 64'h0000_0010_0000_0005);
    check_eq("stall_ready_after", 64'(ready0), 64'd1);

    // Positive overflow: wrap vs saturate
    send(64'h7FFF_FFFF_FFFF_FFFF, 2'b00, 1'b0);
    send(64'd1, 2'b01, 1'b0);
    idle(3);
    check_eq("addovf_w", {hi0, lo0}, 64'h8000_0000_0000_0000);
    check_eq("addovf_s", {hi1, lo1}, 64'h7FFF_FFFF_FFFF_FFFF);
    check_eq("addovf_fw", 64'(ovf0), 64'd1);
    check_eq("addovf_fs", 64'(ovf1), 64'd1);
    clr_ovf = 1'b1;
    m_ovf[0] = 1'b0;
    m_ovf[1] = 1'b0;
    tick();
    clr_ovf = 1'b0;
    check_state("clr");

    // Negative overflow
    send(64'h8000_0000_0000_0000, 2'b00, 1'b0);
    send(64'd1, 2'b10, 1'b0);
    idle(3);
    check_eq("subovf_w", {hi0, lo0}, 64'h7FFF_FFFF_FFFF_FFFF);
    check_eq("subovf_s", {hi1, lo1}, 64'h8000_0000_0000_0000);
    check_state("subovf");

    // Clear and new overflow on the same edge: set wins only where overflow recurs
    send(64'd1, 2'b10, 1'b1);
    prod_valid = 1'b0;
    clr_ovf    = 1'b1;
    tick();
    clr_ovf = 1'b0;
    idle(2);
    check_eq("clrset_fw", 64'(ovf0), 64'd0);
    check_eq("clrset_fs", 64'(ovf1), 64'd1);
    check_state("clrset");

    // Reset right after a transfer discards the buffered product
    do_reset();
    send(64'h0000_00AA_0000_00BB, 2'b00, 1'b0);
    rst        = 1'b1;
    prod_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = '0;
      m_ovf[k] = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
    idle(4);
    check_eq("midrst_acc", {hi0, lo0}, 64'd0);
    check_eq("midrst_ready", 64'(ready0), 64'd1);

    // Reserved op leaves the accumulator alone but still completes
    send(64'h1234, 2'b00, 1'b0);
    send(64'hFFFF_0000_FFFF_0000, 2'b11, 1'b0);
    idle(3);
    check_eq("rsvd_acc", {hi0, lo0}, 64'h1234);
    check_state("rsvd");

    // Mixed random traffic with occasional gaps
    for (int i = 0; i < 12; i++) begin
      logic [63:0] d;
      d = {$urandom(), $urandom()};
      send(d, 2'($urandom_range(0, 2)), 1'b0);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(4);
    check_state("rand");

    check_eq("sb_empty_w", 64'(exp_q0.size()), 64'd0);
    check_eq("sb_empty_s", 64'(exp_q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
